alu_issue_stage: RTL and testbench

Execute-issue stage that sits directly upstream of the 16-bit ALU. It accepts register-form instructions over a valid/ready handshake and reads operands from an internal register file, forwarding the in-flight result where needed. It drives the ALU's A/B/OP inputs from a registered execute stage, then captures the ALU's C/Cout as a write-back result stream. The ALU itself stays an external combinational instance.

---
 rtl/alu_issue_stage.sv | 152 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Execute-issue stage in front of an external combinational ALU: register file, one execute
// register stage with write-back forwarding, and a registered result stream.
module alu_issue_stage #(
  parameter int unsigned NREG  = 4,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic             in_imm_sel,
  input  logic [WIDTH-1:0] in_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_rd,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] rf_q [NREG];

  logic             ex_valid_q, ex_valid_d;
  logic [3:0]       ex_op_q, ex_op_d;
  logic [AW-1:0]    ex_rd_q, ex_rd_d;
  logic [WIDTH-1:0] ex_a_q, ex_a_d;
  logic [WIDTH-1:0] ex_b_q, ex_b_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [AW-1:0]    out_rd_q, out_rd_d;
  logic             out_ovf_q, out_ovf_d;
  logic             ovf_sticky_q, ovf_sticky_d;

  logic             adv;
  logic             accept;
  logic             retire;
  logic             fwd_a;
  logic             fwd_b;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = !ex_valid_q || adv;
  assign accept   = in_valid && in_ready;
  assign retire   = ex_valid_q && adv;

  // Forward the result being written back on this same edge.
  assign fwd_a = retire && (ex_rd_q == in_rs);
  assign fwd_b = retire && (ex_rd_q == in_rt);
  assign src_a = fwd_a ? alu_c : rf_q[in_rs];
  assign src_b = fwd_b ? alu_c : rf_q[in_rt];

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_op_d    = in_op;
      ex_rd_d    = in_rd;
      ex_a_d     = src_a;
      ex_b_d     = in_imm_sel ? in_imm : src_b;
    end else if (retire) begin
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_rd_d     = out_rd_q;
    out_ovf_d    = out_ovf_q;
    ovf_sticky_d = ovf_sticky_q;
    if (retire) begin
      out_valid_d = 1'b1;
      out_data_d  = alu_c;
      out_rd_d    = ex_rd_q;
      out_ovf_d   = alu_cout;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // A same-edge overflow outranks the clear.
    if (retire && alu_cout) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (retire) begin
      rf_q[ex_rd_q] <= alu_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q   <= 1'b0;
      ex_op_q      <= '0;
      ex_rd_q      <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_rd_q     <= '0;
      out_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_op_q      <= ex_op_d;
      ex_rd_q      <= ex_rd_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_rd_q     <= out_rd_d;
      out_ovf_q    <= out_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign alu_a      = ex_a_q;
  assign alu_b      = ex_b_q;
  assign alu_op     = ex_op_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_rd     = out_rd_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = ovf_sticky_q;
  assign dbg_data   = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic checked
// against an in-order architectural model with an explicit queue of in-flight instructions.
module tb_alu_issue_stage;

  localparam int unsigned NREG  = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned AW    = 2;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [AW-1:0]    in_rd;
  logic [AW-1:0]    in_rs;
  logic [AW-1:0]    in_rt;
  logic             in_imm_sel;
  logic [WIDTH-1:0] in_imm;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_c;
  logic             alu_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_rd;
  logic             out_ovf;
  logic             ovf_sticky;
  logic             ovf_clr;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  alu_issue_stage #(
    .NREG (NREG),
    .WIDTH(WIDTH)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_imm_sel(in_imm_sel),
    .in_imm    (in_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_c     (alu_c),
    .alu_cout  (alu_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_ovf   (out_ovf),
    .ovf_sticky(ovf_sticky),
    .ovf_clr   (ovf_clr),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  // Stand-in for the external 16-bit ALU: cout is signed overflow for add/sub, else 0.
  function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] c;
    logic        v;
    v = 1'b0;
    case (op)
      4'd0:    begin c = a + b; v = (a[15] == b[15]) && (c[15] != a[15]); end
      4'd1:    begin c = a - b; v = (a[15] != b[15]) && (c[15] != a[15]); end
      4'd2:    c = a & b;
      4'd3:    c = a | b;
      4'd4:    c = a ^ b;
      4'd9:    c = ~a;
      4'd10:   c = a << 1;
      4'd11:   c = $signed(a) >>> 1;
      default: c = a;
    endcase
    return {v, c};
  endfunction

  assign {alu_cout, alu_c} = alu_f(alu_op, alu_a, alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [3:0]  op;
    logic [1:0]  rd;
    logic        ovf;
    bit          ret;
  } item_t;

  item_t       q[$];
  logic [15:0] spec_rf [NREG];
  logic [15:0] ret_rf  [NREG];
  logic        sticky_m;
  logic [1:0]  dbg_sel;
  int          n_cmp;
  int          n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NREG; i++) begin
      spec_rf[i] = '0;
      ret_rf[i]  = '0;
    end
    sticky_m = 1'b0;
  endtask

  // Called at a negedge: drives inputs, checks outputs, advances one edge, returns at negedge.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [1:0] rt, input logic sel,
                       input logic [15:0] imm, input logic ordy, input logic clr);
    logic        exp_rdy;
    logic        exp_ov;
    logic        acc;
    logic        cons;
    logic [16:0] r;
    item_t       it;
    item_t       h;
    in_valid   = v;
    in_op      = op;
    in_rd      = rd;
    in_rs      = rs;
    in_rt      = rt;
    in_imm_sel = sel;
    in_imm     = imm;
    out_ready  = ordy;
    ovf_clr    = clr;
    dbg_addr   = dbg_sel;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    exp_ov  = (q.size() > 0) && q[0].ret;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_ov) begin
      check_eq("out_data", {16'd0, out_data}, {16'd0, q[0].c});
      check_eq("out_rd", {30'd0, out_rd}, {30'd0, q[0].rd});
      check_eq("out_ovf", {31'd0, out_ovf}, {31'd0, q[0].ovf});
    end
    check_eq("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, sticky_m});
    check_eq("dbg_data", {16'd0, dbg_data}, {16'd0, ret_rf[dbg_sel]});
    if (q.size() > 0 && !q[q.size()-1].ret) begin
      check_eq("alu_a", {16'd0, alu_a}, {16'd0, q[q.size()-1].a});
      check_eq("alu_b", {16'd0, alu_b}, {16'd0, q[q.size()-1].b});
      check_eq("alu_op", {28'd0, alu_op}, {28'd0, q[q.size()-1].op});
    end
    acc  = v && exp_rdy;
    cons = exp_ov && ordy;
    if (acc) begin
      it.a   = spec_rf[rs];
      it.b   = sel ? imm : spec_rf[rt];
      r      = alu_f(op, it.a, it.b);
      it.c   = r[15:0];
      it.ovf = r[16];
      it.op  = op;
      it.rd  = rd;
      it.ret = 1'b0;
      spec_rf[rd] = it.c;
    end
    @(posedge clk);
    if (cons) void'(q.pop_front());
    if (q.size() > 0 && !q[0].ret) begin
      h = q[0];
      h.ret = 1'b1;
      q[0] = h;
      ret_rf[h.rd] = h.c;
      if (h.ovf) sticky_m = 1'b1;
      else if (clr) sticky_m = 1'b0;
    end else if (clr) begin
      sticky_m = 1'b0;
    end
    if (acc) q.push_back(it);
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic sel, input logic [15:0] imm,
                       input logic ordy, input logic clr);
    cycle(1'b1, op, rd, rs, rt, sel, imm, ordy, clr);
  endtask

  task automatic idle(input logic ordy, input logic clr);
    cycle(1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 16'd0, ordy, clr);
  endtask

  logic [3:0]  ops [8];
  logic [15:0] imm_r;

  initial begin
    n_cmp = 0;
    n_err = 0;
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd3;
    ops[4] = 4'd4; ops[5] = 4'd9; ops[6] = 4'd10; ops[7] = 4'd11;
    reset_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0;
    in_imm_sel = 1'b0; in_imm = '0; out_ready = 1'b1; ovf_clr = 1'b0; dbg_addr = '0;
    dbg_sel = '0;
    model_reset();
    #3;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    check_eq("rst_alu_op", {28'd0, alu_op}, 32'd0);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = i[AW-1:0];
      #1;
      check_eq("rst_rf", {16'd0, dbg_data}, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back dependent adds.
    issue(4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    issue(4'd0, 2'd2, 2'd1, 2'd0, 1'b1, 16'h0001, 1'b1, 1'b0);
    check_eq("fwd_r1", {16'd0, out_data}, 32'h7FFF);
    check_eq("fwd_r1_ovf", {31'd0, out_ovf}, 32'd0);
    idle(1'b1, 1'b0);
    check_eq("fwd_r2", {16'd0, out_data}, 32'h8000);
    check_eq("fwd_r2_ovf", {31'd0, out_ovf}, 32'd1);
    check_eq("fwd_sticky", {31'd0, ovf_sticky}, 32'd1);
    dbg_addr = 2'd2;
    #1;
    check_eq("fwd_rf2", {16'd0, dbg_data}, 32'h8000);

    // Subtract overflow, then clear racing a result.
    issue(4'd0, 2'd1, 2'd2, 2'd0, 1'b1, 16'h0000, 1'b1, 1'b0);
    issue(4'd1, 2'd3, 2'd1, 2'd0, 1'b1, 16'h0001, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check_eq("sub_data", {16'd0, out_data}, 32'h7FFF);
    check_eq("sub_ovf", {31'd0, out_ovf}, 32'd1);
    issue(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 16'h0005, 1'b1, 1'b0);
    idle(1'b1, 1'b1);
    check_eq("clr_sticky", {31'd0, ovf_sticky}, 32'd0);
    issue(4'd1, 2'd2, 2'd1, 2'd0, 1'b1, 16'h0001, 1'b1, 1'b0);
    idle(1'b1, 1'b1);
    check_eq("setwins_sticky", {31'd0, ovf_sticky}, 32'd1);
    idle(1'b1, 1'b0);

    // Backpressure: three offered, two accepted.
    issue(4'd0, 2'd3, 2'd0, 2'd0, 1'b1, 16'hA5A0, 1'b0, 1'b0);
    issue(4'd0, 2'd1, 2'd3, 2'd0, 1'b1, 16'h0001, 1'b0, 1'b0);
    check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
    issue(4'd0, 2'd2, 2'd1, 2'd0, 1'b1, 16'h0001, 1'b0, 1'b0);
    check_eq("bp_hold", {16'd0, out_data}, 32'hA5A5);
    idle(1'b0, 1'b0);
    check_eq("bp_hold2", {16'd0, out_data}, 32'hA5A5);
    issue(4'd0, 2'd2, 2'd1, 2'd0, 1'b1, 16'h0001, 1'b1, 1'b0);
    check_eq("bp_second", {16'd0, out_data}, 32'hA5A6);
    idle(1'b1, 1'b0);
    check_eq("bp_third", {16'd0, out_data}, 32'hA5A7);
    idle(1'b1, 1'b0);

    // Logic/shift passthrough on R3 = 0xA5A5.
    issue(4'd9, 2'd1, 2'd3, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("not_alu_op", {28'd0, alu_op}, 32'd9);
    issue(4'd11, 2'd2, 2'd3, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("not_data", {16'd0, out_data}, 32'h5A5A);
    check_eq("sra_alu_op", {28'd0, alu_op}, 32'd11);
    idle(1'b1, 1'b0);
    check_eq("sra_data", {16'd0, out_data}, 32'hD2D2);
    check_eq("sra_ovf", {31'd0, out_ovf}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0:       imm_r = 16'h7FFF;
        1:       imm_r = 16'h8000;
        default: imm_r = 16'($urandom);
      endcase
      dbg_sel = 2'($urandom_range(0, 3));
      cycle(($urandom_range(0, 3) != 0), ops[$urandom_range(0, 7)], 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            imm_r, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
    end
    dbg_sel = '0;
    for (int n = 0; n < 3; n++) idle(1'b1, 1'b0);

    // Async reset with both stages occupied; rd 2 is still in ex.
    issue(4'd0, 2'd3, 2'd0, 2'd0, 1'b1, 16'h1234, 1'b0, 1'b0);
    issue(4'd0, 2'd2, 2'd0, 2'd0, 1'b1, 16'h0055, 1'b0, 1'b0);
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    dbg_addr = 2'd2;
    #1;
    check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_out_data", {16'd0, out_data}, 32'd0);
    check_eq("arst_alu_a", {16'd0, alu_a}, 32'd0);
    check_eq("arst_alu_b", {16'd0, alu_b}, 32'd0);
    check_eq("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("arst_rf2", {16'd0, dbg_data}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("arst_rf2_hold", {16'd0, dbg_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    issue(4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 16'h0042, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) idle(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
